gb_fb_arbiter: RTL
==================

Name: gb_fb_arbiter

Overview:
- Arbitrates one single-port synchronous framebuffer RAM of 160x144 Game Boy pixels between two requesters: the VGA scanout reader and the PPU pixel writer.
- The reader has absolute priority and a fixed latency. Writes are buffered in a small FIFO and drain into idle RAM cycles.
- The block converts (x, y) coordinates to linear addresses and sits between the VGA timing/scanout path and the framebuffer RAM.

Parameters:
- DATA_W, 2, pixel width (2bpp shade).
- ADDR_W, 15, RAM address width; must be at least 15 for 23040 pixels.
- FIFO_DEPTH, 4, write FIFO entries; power of two, 2..16.
- STARVE_LIMIT, 64, consecutive blocked cycles with a full FIFO before wr_starved sets.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rd_req  in  1  single-cycle read request from scanout
- rd_x  in  8  read pixel column
- rd_y  in  8  read pixel row
- rd_valid  out  1  read data valid strobe
- rd_data  out  DATA_W  read pixel data
- wr_valid  in  1  writer offers a pixel
- wr_ready  out  1  FIFO can accept a pixel
- wr_x  in  8  write pixel column
- wr_y  in  8  write pixel row
- wr_data  in  DATA_W  write pixel data
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_addr is presented
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- drop_count  out  8  saturating count of out-of-range writes
- wr_starved  out  1  sticky write-starvation flag

Behaviour:
- Reset (asynchronous, active-high, clock clk) clears all state:
  - rd_valid=0, rd_data=0, mem_addr=0, mem_we=0, mem_wdata=0, fifo_level=0, drop_count=0, wr_starved=0.
  - wr_ready=1 (FIFO empty).
  - In-flight reads are cancelled: no rd_valid after reset release for requests made before reset. FIFO contents are discarded.
- Address: addr = y*160 + x, computed as (y<<7)+(y<<5)+x and zero-extended to ADDR_W. No multiplier. A coordinate is in range iff x<160 and y<144.
- Read path, fixed 2-cycle latency:
  - rd_req sampled high at edge E0 with in-range coordinates: mem_addr<=addr and mem_we<=0 at E0; rd_data<=mem_rdata and rd_valid<=1 at E2 (a one-cycle pulse).
  - Out-of-range read: no RAM access (the slot goes to the writer); rd_valid still pulses at E2 with rd_data=0.
  - Back-to-back rd_req on consecutive cycles is legal; the pipeline is fully pipelined, one result per request, in order.
- Write path:
  - Push occurs when wr_valid && wr_ready at an edge. wr_ready = (fifo_level != FIFO_DEPTH), derived from registered occupancy only. A pop in the same cycle does not make a full FIFO accept.
  - An accepted out-of-range write is consumed (handshake completes), not pushed; drop_count increments and saturates at 255.
  - Each FIFO entry holds the precomputed address plus data.
- Slot scheduling, per edge:
  - If rd_req is high and in range: read slot.
  - Else if the FIFO is non-empty: pop the head; mem_addr<=head addr, mem_wdata<=head data, mem_we<=1.
  - Else: mem_we<=0 and mem_addr holds its value.
- Simultaneous push and pop: occupancy is unchanged; FIFO order is strictly preserved. A write to the same address as a concurrent read returns old RAM data (no forwarding).
- Starvation:
  - A counter increments each cycle in which the FIFO is full, wr_valid=1, and no pop occurs. It clears otherwise.
  - When the count reaches STARVE_LIMIT, wr_starved sets and stays set until reset.
- fifo_level is registered and updates on the edge of the push/pop.

Test Plan:
- Write then read, idle reader: write (x=5,y=2,d=3) → mem_we=1 with mem_addr=325 one cycle after acceptance. Later rd_req(5,2) → rd_valid pulses 2 cycles after the request with rd_data=3.
- Read priority: FIFO holds 2 entries and rd_req is held high 3 cycles in range → no mem_we during those cycles, 3 rd_valid pulses in order, then the 2 writes drain on the next 2 cycles.
- FIFO full: 4 writes pushed while rd_req is continuous → wr_ready=0 with fifo_level=4. A 5th wr_valid is not accepted until a pop; after STARVE_LIMIT=64 blocked cycles, wr_starved=1.
- Out of range: write (x=160,y=0) → accepted, not pushed, drop_count=1. Read (x=0,y=144) → rd_data=0, rd_valid at +2, and the slot is used by a pending write. 256+ drops → drop_count stays 255.
- Corner address: write/read at (159,143) → mem_addr=23039. Data round-trips correctly.
- Reset mid-operation: assert reset with 3 FIFO entries and 2 reads in flight → rd_valid never pulses, fifo_level=0, wr_ready=1, mem_we=0 immediately (asynchronous); no RAM writes occur after release.

Source files
------------

// File: rtl/gb_fb_arbiter.sv
// rtl/gb_fb_arbiter.sv - framebuffer RAM arbiter: priority scanout reads, FIFO-buffered PPU writes
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   rd_req_i/x_i/y_i   scanout read request and pixel coordinates
//   rd_valid_o/data_o  read result, fixed two cycles after the request
//   wr_valid_i/ready_o writer handshake; wr_x_i/wr_y_i/wr_data_i pixel to write
//   mem_*              registered single-port synchronous RAM interface
//   fifo_level_o       write FIFO occupancy
//   drop_count_o       saturating count of out-of-range writes
//   wr_starved_o       sticky flag: writer blocked on a full FIFO too long
module gb_fb_arbiter #(
    parameter int DATA_W       = 2,
    parameter int ADDR_W       = 15,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 64,
    localparam int LW          = $clog2(FIFO_DEPTH) + 1,
    localparam int PW          = $clog2(FIFO_DEPTH),
    localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req_i,
    input  logic [7:0]        rd_x_i,
    input  logic [7:0]        rd_y_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [7:0]        wr_x_i,
    input  logic [7:0]        wr_y_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [LW-1:0]     fifo_level_o,
    output logic [7:0]        drop_count_o,
    output logic              wr_starved_o
);

    // y*160 + x as two shifts and an add.
    function automatic logic [ADDR_W-1:0] xy_addr(input logic [7:0] x, input logic [7:0] y);
        logic [ADDR_W-1:0] ye;
        ye = ADDR_W'(y);
        return (ye << 7) + (ye << 5) + ADDR_W'(x);
    endfunction

    function automatic logic in_range(input logic [7:0] x, input logic [7:0] y);
        return (x < 8'd160) && (y < 8'd144);
    endfunction

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [7:0]        drop_q, drop_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic              starved_q, starved_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    // Read pipeline: stage 1 covers the RAM access cycle, stage 2 the RAM output cycle.
    logic              p1_vld_q, p1_hit_q, p2_vld_q, p2_hit_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic rd_hit, wr_fire, push, drop, pop, blocked;

    always_comb begin
        rd_hit     = rd_req_i && in_range(rd_x_i, rd_y_i);
        // Ready depends only on registered occupancy so a same-cycle pop never admits a push to a full FIFO.
        wr_ready_o = (level_q != LW'(FIFO_DEPTH));
        wr_fire    = wr_valid_i && wr_ready_o;
        push       = wr_fire && in_range(wr_x_i, wr_y_i);
        drop       = wr_fire && !in_range(wr_x_i, wr_y_i);
        pop        = !rd_hit && (level_q != '0);
        blocked    = !wr_ready_o && wr_valid_i && !pop;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
        drop_d   = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

        starve_cnt_d = '0;
        if (blocked) begin
            starve_cnt_d = (starve_cnt_q == SW'(STARVE_LIMIT)) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
        starved_d = starved_q || (blocked && starve_cnt_q == SW'(STARVE_LIMIT - 1));

        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        if (rd_hit) begin
            mem_addr_d = xy_addr(rd_x_i, rd_y_i);
        end else if (pop) begin
            mem_addr_d  = fifo_addr_q[rd_ptr_q];
            mem_wdata_d = fifo_data_q[rd_ptr_q];
            mem_we_d    = 1'b1;
        end

        // Out-of-range reads never touched the RAM, so their result is forced to zero.
        rd_data_d = p2_hit_q ? mem_rdata_i : '0;
    end

    // FIFO payload needs no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= xy_addr(wr_x_i, wr_y_i);
            fifo_data_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            drop_q       <= '0;
            starve_cnt_q <= '0;
            starved_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            p1_vld_q     <= 1'b0;
            p1_hit_q     <= 1'b0;
            p2_vld_q     <= 1'b0;
            p2_hit_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            drop_q       <= drop_d;
            starve_cnt_q <= starve_cnt_d;
            starved_q    <= starved_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            p1_vld_q     <= rd_req_i;
            p1_hit_q     <= rd_hit;
            p2_vld_q     <= p1_vld_q;
            p2_hit_q     <= p1_hit_q;
            rd_valid_q   <= p2_vld_q;
            rd_data_q    <= rd_data_d;
        end
    end

    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_we_o     = mem_we_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign fifo_level_o = level_q;
    assign drop_count_o = drop_q;
    assign wr_starved_o = starved_q;

endmodule
